nixie_tube_serializer: RTL and testbench

//  Downstream of the clock state storage. Takes hour/minute/second (6-bit binary) and cursorPos,

---
 rtl/nixie_pkg.sv | 25 ++
 rtl/bin6_to_bcd2.sv | 23 ++
 rtl/nixie_tube_serializer.sv | 164 ++++++++++++++++
 tb/tb_nixie_tube_serializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nixie_pkg.sv
// Shared constants, cursor encodings and FSM states for the nixie tube serializer.
package nixie_pkg;

    localparam int NUM_TUBES  = 6;
    localparam int CATHODES   = 10;
    localparam int FRAME_BITS = NUM_TUBES * CATHODES;

    localparam logic [2:0] CUR_SEC  = 3'b001;
    localparam logic [2:0] CUR_MIN  = 3'b010;
    localparam logic [2:0] CUR_HOUR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_LATCH
    } serState_t;

    // One cathode per digit; bit k lights digit k.
    function automatic logic [CATHODES-1:0] digitOneHot(input logic [3:0] digit);
        return CATHODES'(1) << digit;
    endfunction

endpackage

// File: rtl/bin6_to_bcd2.sv
// 6-bit binary to two BCD digits; valid only for values 0..59.
module bin6_to_bcd2 (
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);
    logic [5:0] rem;

    // Tens by range comparison, ones as the remainder.
    always_comb begin
        tens = 4'd0;
        if      (value >= 6'd50) tens = 4'd5;
        else if (value >= 6'd40) tens = 4'd4;
        else if (value >= 6'd30) tens = 4'd3;
        else if (value >= 6'd20) tens = 4'd2;
        else if (value >= 6'd10) tens = 4'd1;
        rem   = value - ({2'b00, tens} * 6'd10);
        ones  = rem[3:0];
        valid = (value < 6'd60);
    end

endmodule

// File: rtl/nixie_tube_serializer.sv
// Builds a 60-bit one-hot cathode frame from h:m:s and shifts it into the HV driver chain.
module nixie_tube_serializer
    import nixie_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLINK_FRAMES   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [2:0] cursorPos,
    input  logic       blink_en,
    output logic       sr_clk,
    output logic       sr_data,
    output logic       sr_latch,
    output logic       sr_blank_n,
    output logic       busy,
    output logic       frame_done
);
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    serState_t             state;
    logic [RW-1:0]         refreshCnt;
    logic                  refreshWrap;
    logic                  pending;
    logic                  consume;
    logic [DW-1:0]         divCnt;
    logic                  divLast;
    logic [5:0]            bitCnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frameNext;
    logic [BW-1:0]         blinkCnt;
    logic                  blinkPhase;

    logic [3:0] hT, hO, mT, mO, sT, sO;
    logic       hV, mV, sV;

    bin6_to_bcd2 uHour (.value(hour),   .tens(hT), .ones(hO), .valid(hV));
    bin6_to_bcd2 uMin  (.value(minute), .tens(mT), .ones(mO), .valid(mV));
    bin6_to_bcd2 uSec  (.value(second), .tens(sT), .ones(sO), .valid(sV));

    assign refreshWrap = (refreshCnt == RW'(REFRESH_CYCLES - 1));
    assign divLast     = (divCnt == DW'(CLK_DIV - 1));
    // A request is taken either from IDLE or straight out of the latch phase.
    assign consume     = pending && ((state == ST_IDLE) || (state == ST_LATCH && divLast));

    // Frame image: invalid values and the blinked cursor pair go dark.
    always_comb begin
        logic blankSel;
        blankSel  = blink_en && blinkPhase;
        frameNext = '0;
        if (hV && !(blankSel && cursorPos == CUR_HOUR))
            frameNext[59:40] = {digitOneHot(hT), digitOneHot(hO)};
        if (mV && !(blankSel && cursorPos == CUR_MIN))
            frameNext[39:20] = {digitOneHot(mT), digitOneHot(mO)};
        if (sV && !(blankSel && cursorPos == CUR_SEC))
            frameNext[19:0]  = {digitOneHot(sT), digitOneHot(sO)};
    end

    // Refresh timebase; a single pending request, a new wrap wins over consumption.
    always_ff @(posedge clk) begin
        if (reset) begin
            refreshCnt <= '0;
            pending    <= 1'b1;
        end else begin
            refreshCnt <= refreshWrap ? '0 : refreshCnt + 1'b1;
            if (refreshWrap)  pending <= 1'b1;
            else if (consume) pending <= 1'b0;
        end
    end

    // Frame FSM: load, 60 shift-clock periods, latch strobe; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sr_clk     <= 1'b0;
            sr_data    <= 1'b0;
            sr_latch   <= 1'b0;
            sr_blank_n <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            divCnt     <= '0;
            bitCnt     <= '0;
            shreg      <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shreg   <= frameNext;
                    sr_data <= frameNext[FRAME_BITS-1];
                    sr_clk  <= 1'b0;
                    divCnt  <= '0;
                    bitCnt  <= '0;
                    state   <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (divLast) begin
                        divCnt <= '0;
                        sr_clk <= 1'b1;
                        state  <= ST_SHIFT_HI;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (divLast) begin
                        divCnt <= '0;
                        sr_clk <= 1'b0;
                        if (bitCnt == 6'(FRAME_BITS - 1)) begin
                            sr_latch <= 1'b1;
                            state    <= ST_LATCH;
                        end else begin
                            bitCnt  <= bitCnt + 1'b1;
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                            sr_data <= shreg[FRAME_BITS-2];
                            state   <= ST_SHIFT_LO;
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (divLast) begin
                        divCnt     <= '0;
                        sr_latch   <= 1'b0;
                        frame_done <= 1'b1;
                        sr_blank_n <= 1'b1;
                        if (blinkCnt == BW'(BLINK_FRAMES - 1)) begin
                            blinkCnt   <= '0;
                            blinkPhase <= ~blinkPhase;
                        end else begin
                            blinkCnt <= blinkCnt + 1'b1;
                        end
                        // Back-to-back frames skip the idle cycle so starts stay one frame apart.
                        if (pending) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nixie_tube_serializer.sv
// Scoreboard bench: stimulus queues expected frames, monitors compare at each latch strobe.
module tb_nixie_tube_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] hour, minute, second;
    logic [2:0] cursorPos;
    logic       blink_en;

    logic srClkA, srDataA, srLatchA, blankA, busyA, doneA;
    logic srClkB, srDataB, srLatchB, blankB, busyB, doneB;

    nixie_tube_serializer #(.CLK_DIV(4), .REFRESH_CYCLES(1000), .BLINK_FRAMES(2)) dutA (
        .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second),
        .cursorPos(cursorPos), .blink_en(blink_en),
        .sr_clk(srClkA), .sr_data(srDataA), .sr_latch(srLatchA), .sr_blank_n(blankA),
        .busy(busyA), .frame_done(doneA));

    nixie_tube_serializer #(.CLK_DIV(4), .REFRESH_CYCLES(100), .BLINK_FRAMES(2)) dutB (
        .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second),
        .cursorPos(cursorPos), .blink_en(blink_en),
        .sr_clk(srClkB), .sr_data(srDataB), .sr_latch(srLatchB), .sr_blank_n(blankB),
        .busy(busyB), .frame_done(doneB));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [59:0] expQ[$];
    int nTests = 0;
    int nFail  = 0;
    int nBitsA = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: collect bits on sr_clk rises, compare frame at latch, check timing.
    initial begin
        logic        prevClk, prevLatch, doneValid;
        logic [59:0] got, exp;
        int          lastRise, latchLen, lastDone;
        prevClk = 0; prevLatch = 0; doneValid = 0; got = '0;
        lastRise = 0; latchLen = 0; lastDone = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                nBitsA = 0; prevClk = 0; prevLatch = 0; latchLen = 0; doneValid = 0;
            end else begin
                if (srClkA && !prevClk) begin
                    if (nBitsA > 0) chk("srclk_period", 64'(cyc - lastRise), 64'd8);
                    got = {got[58:0], srDataA};
                    nBitsA++;
                    lastRise = cyc;
                end
                if (srLatchA) latchLen++;
                if (srLatchA && !prevLatch) begin
                    if (expQ.size() == 0) begin
                        nTests++; nFail++;
                        $display("FAIL unexpected_latch: got latch with %0d bits, expected none", nBitsA);
                    end else begin
                        exp = expQ.pop_front();
                        chk("frame_bits", 64'(nBitsA), 64'd60);
                        chk("frame_data", 64'(got), 64'(exp));
                    end
                end
                if (!srLatchA && prevLatch) begin
                    chk("latch_width", 64'(latchLen), 64'd4);
                    chk("done_on_latch_fall", 64'(doneA), 64'd1);
                    latchLen = 0;
                    nBitsA = 0;
                end
                if (doneA) begin
                    if (doneValid) chk("done_spacing_1000", 64'(cyc - lastDone), 64'd1000);
                    lastDone = cyc;
                    doneValid = 1;
                end
                prevClk = srClkA;
                prevLatch = srLatchA;
            end
        end
    end

    // Monitor B: back-to-back frames when refresh is shorter than a frame.
    initial begin
        logic doneValid;
        int   lastDone;
        doneValid = 0; lastDone = 0;
        forever begin
            @(negedge clk);
            if (reset) doneValid = 0;
            else if (doneB) begin
                if (doneValid) chk("done_spacing_485", 64'(cyc - lastDone), 64'd485);
                lastDone = cyc;
                doneValid = 1;
            end
        end
    end

    task automatic waitDone();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!doneA && k < 3000);
        if (!doneA) begin
            nTests++; nFail++;
            $display("FAIL wait_frame_done: got timeout, expected frame_done");
        end
    endtask

    task automatic waitBits(input int n);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (nBitsA < n && k < 3000);
        if (nBitsA < n) begin
            nTests++; nFail++;
            $display("FAIL wait_bits: got %0d bits, expected %0d", nBitsA, n);
        end
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, "_sr_clk"},   64'(srClkA),   64'd0);
        chk({tag, "_sr_data"},  64'(srDataA),  64'd0);
        chk({tag, "_sr_latch"}, 64'(srLatchA), 64'd0);
        chk({tag, "_blank_n"},  64'(blankA),   64'd0);
        chk({tag, "_busy"},     64'(busyA),    64'd0);
        chk({tag, "_done"},     64'(doneA),    64'd0);
    endtask

    initial begin
        logic [59:0] f1, f1Blank, f2, f12a, f12b;
        f1      = {10'h002, 10'h008, 10'h010, 10'h020, 10'h001, 10'h080};
        f1Blank = {f1[59:20], 20'h0};
        f2      = {10'h001, 10'h200, 10'h000, 10'h000, 10'h008, 10'h001};
        f12a    = {10'h002, 10'h004, 10'h001, 10'h001, 10'h001, 10'h001};
        f12b    = {10'h002, 10'h004, 10'h001, 10'h001, 10'h001, 10'h002};

        // 13:45:07 after reset; first frame starts immediately
        hour = 6'd13; minute = 6'd45; second = 6'd7; cursorPos = 3'b000; blink_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chkResetVals("reset");
        expQ.push_back(f1);
        reset = 1'b0;
        @(negedge clk);
        chk("first_frame_start", 64'(busyA), 64'd1);
        waitDone();
        chk("blank_n_after_frame", 64'(blankA), 64'd1);
        chk("busy_after_frame", 64'(busyA), 64'd0);

        // out-of-range minute blanks its pair
        hour = 6'd9; minute = 6'd60; second = 6'd30;
        expQ.push_back(f2);
        waitDone();

        // input change mid-frame only shows up in the following frame
        hour = 6'd12; minute = 6'd0; second = 6'd0;
        expQ.push_back(f12a);
        waitBits(20);
        second = 6'd1;
        expQ.push_back(f12b);
        waitDone();
        waitDone();

        // blink on seconds; phases of 2 frames; invalid cursor never blanks
        reset = 1'b1;
        hour = 6'd13; minute = 6'd45; second = 6'd7; cursorPos = 3'b001; blink_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            expQ.push_back((i == 2 || i == 3) ? f1Blank : f1);
        for (int i = 0; i < 8; i++) begin
            waitDone();
            if (i == 5) cursorPos = 3'b011;
        end

        // reset mid-frame aborts without a latch; fresh frame follows
        blink_en = 1'b0; cursorPos = 3'b000;
        waitBits(30);
        reset = 1'b1;
        @(negedge clk);
        chkResetVals("abort");
        expQ.push_back(f1);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_frame_start", 64'(busyA), 64'd1);
        waitDone();
        chk("blank_n_after_restart", 64'(blankA), 64'd1);

        repeat (10) @(negedge clk);
        chk("queue_drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
